// File: rtl/store_buffer_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : store_buffer_unit                                               |
// | Brief    : MEM-stage store queue. Aligns stores, drains them to data       |
// |            memory over req/ack and flags loads hitting pending stores.     |
// | Options  : `define MISALIGN_TRAP_EN to reject misaligned SH/SW stores.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module store_buffer_unit #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] Read_data_sw,
  input  logic [2:0]        st_funct3,
  output logic              st_stall,
  output logic              st_misalign,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_conflict,
  output logic              dm_req,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic [3:0]        dm_be,
  input  logic              dm_ack,
  output logic              sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [2:0]    C_F3_SB = 3'b000;
  localparam logic [2:0]    C_F3_SH = 3'b001;
  localparam logic [2:0]    C_F3_SW = 3'b010;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              sb_empty_q, sb_empty_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [3:0]        be_q   [DEPTH];
  logic [3:0]        be_d   [DEPTH];

  logic              f3_legal;
  logic              misalign;
  logic              trap;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_data;
  logic              full;
  logic              push;
  logic              pop;
  logic              addr_hit;
  logic              unused_ld_lo;

  // Lane replication assumes a 32-bit data path.
  always_comb begin
    f3_legal = 1'b0;
    misalign = 1'b0;
    al_be    = 4'b0000;
    al_data  = Read_data_sw;
    case (st_funct3)
      C_F3_SB: begin
        f3_legal = 1'b1;
        al_be    = 4'b0001 << st_addr[1:0];
        al_data  = {4{Read_data_sw[7:0]}};
      end
      C_F3_SH: begin
        f3_legal = 1'b1;
        misalign = st_addr[0];
        al_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        al_data  = {2{Read_data_sw[15:0]}};
      end
      C_F3_SW: begin
        f3_legal = 1'b1;
        misalign = |st_addr[1:0];
        al_be    = 4'b1111;
      end
      default: begin
        f3_legal = 1'b0;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = st_valid && misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign trap            = 1'b0;
`endif

  assign st_misalign = trap;
  assign full        = (count_q == C_FULL);
  // A full queue never accepts, even when the head pops this cycle.
  assign push        = st_valid && f3_legal && !trap && !full;
  assign st_stall    = st_valid && f3_legal && !trap && full;
  assign pop         = (state_q == S_REQ) && dm_ack;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      addr_d[tail_q] = {st_addr[ADDR_W-1:2], 2'b00};
      data_d[tail_q] = al_data;
      be_d[tail_q]   = al_be;
      tail_d         = tail_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    sb_empty_d = (count_d == '0);
  end

  // Transition uses next count so the request follows the push edge directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (push) state_d = S_REQ;
      S_REQ:  if (pop && (count_d == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      sb_empty_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      sb_empty_q <= sb_empty_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
        be_q[i]   <= be_d[i];
      end
    end
  end

  always_comb begin
    addr_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) &&
          (addr_q[head_q + PW'(k)][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        addr_hit = 1'b1;
      end
    end
  end

  assign unused_ld_lo = ^ld_addr[1:0];
  assign ld_conflict  = ld_valid && addr_hit;

  assign dm_req   = (state_q == S_REQ);
  assign dm_addr  = dm_req ? addr_q[head_q] : '0;
  assign dm_wdata = dm_req ? data_q[head_q] : '0;
  assign dm_be    = dm_req ? be_q[head_q]   : 4'b0000;
  assign sb_empty = sb_empty_q;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer_unit.sv
`default_nettype none
// Testbench for store_buffer_unit: directed vector table, then random traffic
// checked against a queue-based reference model.
module tb_store_buffer_unit;

  localparam int DEPTH = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_stall;
  logic        st_misalign;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic        sb_empty;

  int total = 0;
  int bad   = 0;

  store_buffer_unit #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .Read_data_sw (st_data),
    .st_funct3    (st_funct3),
    .st_stall     (st_stall),
    .st_misalign  (st_misalign),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_conflict  (ld_conflict),
    .dm_req       (dm_req),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_be        (dm_be),
    .dm_ack       (dm_ack),
    .sb_empty     (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stv;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f3;
    logic        ldv;
    logic [31:0] la;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_stall;
    logic        e_conf;
    logic        e_empty;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic sv, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f, input logic lv, input logic [31:0] la, input logic ak,
                     input logic er, input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] eb,
                     input logic es, input logic ec, input logic ee, input logic em);
    vec_t v;
    v.rst = r; v.stv = sv; v.a = a; v.d = d; v.f3 = f; v.ldv = lv; v.la = la; v.ack = ak;
    v.e_req = er; v.e_addr = ea; v.e_wdata = ew; v.e_be = eb;
    v.e_stall = es; v.e_conf = ec; v.e_empty = ee; v.e_mis = em;
    tbl.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic er, input logic [31:0] ea,
                               input logic [31:0] ew, input logic [3:0] eb, input logic es,
                               input logic ec, input logic ee, input logic em);
    chk({tag, " dm_req"},      32'(dm_req),      32'(er));
    chk({tag, " st_stall"},    32'(st_stall),    32'(es));
    chk({tag, " ld_conflict"}, 32'(ld_conflict), 32'(ec));
    chk({tag, " sb_empty"},    32'(sb_empty),    32'(ee));
    chk({tag, " st_misalign"}, 32'(st_misalign), 32'(em));
    if (er) begin
      chk({tag, " dm_addr"},  dm_addr,       ea);
      chk({tag, " dm_wdata"}, dm_wdata,      ew);
      chk({tag, " dm_be"},    32'(dm_be),    32'(eb));
    end
  endtask

  // Reference alignment written from the byte-lane rules with arithmetic.
  task automatic ref_align(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                           output logic legal, output logic mis, output ent_t e);
    int off;
    off   = int'(a[1:0]);
    legal = 1'b1;
    mis   = 1'b0;
    e.a   = a & 32'hFFFF_FFFC;
    e.d   = d;
    e.be  = 4'hF;
    if (f == 3'd0) begin
      e.be = 4'(1 << off);
      e.d  = 32'(d[7:0]) * 32'h0101_0101;
    end else if (f == 3'd1) begin
      e.be = 4'(3 << (2 * (off / 2)));
      e.d  = 32'(d[15:0]) * 32'h0001_0001;
      mis  = (off % 2) != 0;
    end else if (f == 3'd2) begin
      mis  = off != 0;
    end else begin
      legal = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
    ld_valid = 1'b0; ld_addr = '0; dm_ack = 1'b0;

    //   rst sv addr          data          f3 lv ldaddr        ak | req addr          wdata         be       st cf em mis
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      0,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    add(0, 1, 32'h1003,   32'hA5,       0, 0, 32'h0,      1,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      1,   1, 32'h1000,   32'hA5A5A5A5, 4'b1000, 0, 0, 0, 0);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      1,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    add(0, 1, 32'h2002,   32'h1234BEEF, 1, 0, 32'h0,      0,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    add(0, 0, 32'h0,      32'h0,        0, 1, 32'h2000,   0,   1, 32'h2000,   32'hBEEFBEEF, 4'b1100, 0, 1, 0, 0);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      1,   1, 32'h2000,   32'hBEEFBEEF, 4'b1100, 0, 0, 0, 0);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      0,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    // three back-to-back words into a two-entry queue with memory stalled
    add(0, 1, 32'h5000,   32'h11111111, 2, 0, 32'h0,      0,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    add(0, 1, 32'h5004,   32'h22222222, 2, 0, 32'h0,      0,   1, 32'h5000,   32'h11111111, 4'b1111, 0, 0, 0, 0);
    add(0, 1, 32'h5008,   32'h33333333, 2, 0, 32'h0,      0,   1, 32'h5000,   32'h11111111, 4'b1111, 1, 0, 0, 0);
    add(0, 1, 32'h5008,   32'h33333333, 2, 0, 32'h0,      0,   1, 32'h5000,   32'h11111111, 4'b1111, 1, 0, 0, 0);
    add(0, 1, 32'h5008,   32'h33333333, 2, 0, 32'h0,      1,   1, 32'h5000,   32'h11111111, 4'b1111, 1, 0, 0, 0);
    add(0, 1, 32'h5008,   32'h33333333, 2, 0, 32'h0,      0,   1, 32'h5004,   32'h22222222, 4'b1111, 0, 0, 0, 0);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      1,   1, 32'h5004,   32'h22222222, 4'b1111, 0, 0, 0, 0);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      1,   1, 32'h5008,   32'h33333333, 4'b1111, 0, 0, 0, 0);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      0,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    // load-hit detection around a pending word
    add(0, 1, 32'h3000,   32'hCAFEF00D, 2, 1, 32'h3000,   0,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    add(0, 0, 32'h0,      32'h0,        0, 1, 32'h3002,   0,   1, 32'h3000,   32'hCAFEF00D, 4'b1111, 0, 1, 0, 0);
    add(0, 0, 32'h0,      32'h0,        0, 1, 32'h3004,   0,   1, 32'h3000,   32'hCAFEF00D, 4'b1111, 0, 0, 0, 0);
    add(0, 0, 32'h0,      32'h0,        0, 1, 32'h3002,   1,   1, 32'h3000,   32'hCAFEF00D, 4'b1111, 0, 1, 0, 0);
    add(0, 0, 32'h0,      32'h0,        0, 1, 32'h3002,   0,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    // reset with two entries queued
    add(0, 1, 32'h6000,   32'h66,       2, 0, 32'h0,      0,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    add(0, 1, 32'h6004,   32'h64,       2, 0, 32'h0,      0,   1, 32'h6000,   32'h66,       4'b1111, 0, 0, 0, 0);
    add(1, 0, 32'h0,      32'h0,        0, 0, 32'h0,      0,   1, 32'h6000,   32'h66,       4'b1111, 0, 0, 0, 0);
    add(0, 0, 32'h0,      32'h0,        0, 1, 32'h6000,   1,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    add(0, 1, 32'h7000,   32'h77777777, 2, 0, 32'h0,      1,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      0,   1, 32'h7000,   32'h77777777, 4'b1111, 0, 0, 0, 0);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      1,   1, 32'h7000,   32'h77777777, 4'b1111, 0, 0, 0, 0);
    // misaligned word
    add(0, 1, 32'h4001,   32'hDEADBEEF, 2, 0, 32'h0,      0,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, TRAP);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      1,   !TRAP, 32'h4000, 32'hDEADBEEF, 4'b1111, 0, 0, TRAP, 0);
    // illegal funct3 is dropped, then a byte store at offset 1
    add(0, 1, 32'h8000,   32'h12345678, 3, 0, 32'h0,      0,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      0,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    add(0, 1, 32'h9001,   32'h5A,       0, 0, 32'h0,      1,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      1,   1, 32'h9000,   32'h5A5A5A5A, 4'b0010, 0, 0, 0, 0);
    add(0, 0, 32'h0,      32'h0,        0, 0, 32'h0,      0,   0, 32'h0,      32'h0,        4'b0000, 0, 0, 1, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; st_valid = tbl[i].stv; st_addr = tbl[i].a; st_data = tbl[i].d;
      st_funct3 = tbl[i].f3; ld_valid = tbl[i].ldv; ld_addr = tbl[i].la; dm_ack = tbl[i].ack;
      #1;
      check_outputs($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_wdata,
                    tbl[i].e_be, tbl[i].e_stall, tbl[i].e_conf, tbl[i].e_empty, tbl[i].e_mis);
    end

    // Random traffic against the queue model; the table leaves the queue empty.
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        legal, mis, accept, is_full, hit, do_push, do_pop;
      logic [31:0] ea, ew;
      logic [3:0]  eb;
      ent_t        e;
      int          sel;
      @(negedge clk);
      rst      = ($urandom_range(0, 59) == 0);
      st_valid = ($urandom_range(0, 9) < 6);
      st_addr  = 32'h0000_A000 | 32'($urandom_range(0, 15));
      st_data  = $urandom;
      sel      = $urandom_range(0, 7);
      st_funct3 = (sel < 2) ? 3'd0 : (sel < 4) ? 3'd1 : (sel < 7) ? 3'd2 : 3'($urandom_range(3, 7));
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_addr  = 32'h0000_A000 | 32'($urandom_range(0, 15));
      dm_ack   = ($urandom_range(0, 9) < 6);
      #1;
      ref_align(st_addr, st_data, st_funct3, legal, mis, e);
      mis     = TRAP && st_valid && legal && mis;
      accept  = legal && !mis;
      is_full = (mq.size() == DEPTH);
      hit     = 1'b0;
      foreach (mq[k]) if (mq[k].a[31:2] == ld_addr[31:2]) hit = 1'b1;
      ea = '0; ew = '0; eb = '0;
      if (mq.size() != 0) begin
        ea = mq[0].a; ew = mq[0].d; eb = mq[0].be;
      end
      check_outputs($sformatf("rnd%0d", cyc), mq.size() != 0, ea, ew, eb,
                    st_valid && accept && is_full, ld_valid && hit, mq.size() == 0, mis);
      do_pop  = dm_ack && (mq.size() != 0);
      do_push = st_valid && accept && !is_full;
      @(posedge clk);
      if (rst) begin
        mq.delete();
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(e);
      end
    end

    @(negedge clk);
    rst = 1'b0; st_valid = 1'b0; ld_valid = 1'b0; dm_ack = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
- MEM-stage store path, directly downstream of the store-data forwarding mux.
- Takes the forwarded store operand (Read_data_sw), address and funct3, and byte-aligns them with byte enables.
- Queues stores in a small FIFO and drains them to data memory through a req/ack handshake.
- Stalls the pipeline only when the queue is full, and flags loads that hit a pending store.

Parameters:
- DEPTH, 2: store queue entries; power of two, 2..8.
- ADDR_W, 32: byte address width.
- DATA_W, 32: data width; fixed to `data_size; only 32 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request from MEM stage
- st_addr  in  ADDR_W  store byte address
- Read_data_sw  in  DATA_W  store data from the forwarding mux
- st_funct3  in  3  000=SB, 001=SH, 010=SW
- st_stall  out  1  queue full; hold the MEM stage
- st_misalign  out  1  misaligned store dropped (MISALIGN_TRAP_EN only)
- ld_valid  in  1  load in MEM stage
- ld_addr  in  ADDR_W  load byte address
- ld_conflict  out  1  load word matches a pending store
- dm_req  out  1  memory write request
- dm_addr  out  ADDR_W  word-aligned address; [1:0]=0
- dm_wdata  out  DATA_W  aligned write data
- dm_be  out  4  active-high byte enables
- dm_ack  in  1  memory accepted the head entry
- sb_empty  out  1  queue empty; used for fence/drain

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=0; head and tail pointers = 0.
  - FSM to IDLE.
  - dm_req=0, dm_addr=0, dm_wdata=0, dm_be=0.
  - sb_empty=1, st_stall=0, st_misalign=0.
  - Reset mid-drain flushes all entries; no write is retried.
  - dm_ack while in IDLE is ignored.
- Alignment (combinational, at push), with off=st_addr[1:0]:
  - SB: be = 4'b0001<<off; data = byte0 replicated to all four byte lanes.
  - SH: be = 0011 when st_addr[1]=0, 1100 when st_addr[1]=1; data = halfword0 replicated to both halves.
  - SW: be = 1111; data unchanged.
  - Any other funct3: not pushed, no stall.
  - Stored entry address is st_addr with [1:0] cleared.
- Misaligned stores without the macro: SH with addr[0]=1, or SW with addr[1:0]!=0. The low address bits are ignored and the store proceeds as if aligned.
- Push: st_valid && legal funct3 && count<DEPTH. The entry is written at the tail on the clk edge.
- st_stall is combinational: st_valid && count==DEPTH.
  - No push while full, even if dm_ack pops in the same cycle.
  - The stalled store is accepted on the first cycle after count<DEPTH.
- Pop: dm_ack while dm_req=1. The head advances.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- Drain FSM states: IDLE, REQ.
  - IDLE -> REQ when count>0 (registered). dm_req=1 and head-entry outputs are valid the cycle after the push edge; minimum push-to-req latency is 1 cycle.
  - REQ: dm_req, dm_addr, dm_wdata and dm_be stay stable until dm_ack.
  - On ack with a remaining entry: stay in REQ and present the next entry the following cycle (back-to-back; dm_req stays high).
  - On ack with no remaining entry: go to IDLE; dm_req=0 the following cycle.
- ld_conflict is combinational: ld_valid && a valid entry with addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2].
  - The in-flight head entry counts until it is acked.
  - The entry being pushed in the same cycle is excluded.
  - The pipeline stalls the load while ld_conflict=1.
- sb_empty = (count==0), registered.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned SH/SW is not pushed.
  - st_misalign=1 combinationally in that cycle; st_stall=0.
  - The core raises a store-address-misaligned exception.
  - SB is never misaligned.
- Undefined:
  - st_misalign is tied to 0.
  - Misaligned stores are silently aligned down, as in Behaviour.

Test Plan:
- SB at addr 0x1003, data 0x000000A5, dm_ack held 1 -> next cycle dm_req=1, dm_addr=0x1000, dm_be=1000, dm_wdata=0xA5A5A5A5; sb_empty=1 two cycles after the push.
- SH at 0x2002, data 0x1234BEEF -> dm_be=1100, dm_wdata=0xBEEFBEEF, dm_addr=0x2000.
- DEPTH=2 with dm_ack held 0, SW x3 back-to-back -> third cycle st_stall=1; dm_req stays on entry 0 with stable outputs; raise dm_ack -> third SW pushed the cycle after the first pop; entries drain in order.
- SW 0x3000 pending, ld_valid with ld_addr=0x3002 -> ld_conflict=1; with ld_addr=0x3004 -> ld_conflict=0; after the ack of 0x3000, ld_conflict=0 for 0x3002.
- rst=1 while dm_req=1 and count=2 -> next cycle dm_req=0, sb_empty=1; a later dm_ack causes no pop or underflow.
- With MISALIGN_TRAP_EN: SW at 0x4001 -> st_misalign=1, nothing pushed, dm_req stays 0. Without it: dm_addr=0x4000, dm_be=1111.
